pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Hazard and sequencing controller for the five-stage pipeline (fetch, decode, execute, memory, writeback). It owns the per-stage advance and bubble decisions for the inter-stage registers, driven by instruction-bus and data-bus handshakes, load-use hazards and decode-resolved branches. It also tracks the single outstanding fetch, so a wrong-path response arriving after a branch is discarded and the redirect is delivered to fetch exactly once.

## Interface
- ADDR_W, 64, PC / branch target width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_req_valid  in  1  fetch is presenting an instruction request
- i_data_ok  in  1  instruction response valid this cycle
- d_req_valid  in  1  memory stage is presenting a data request
- d_data_ok  in  1  data response valid this cycle
- br_taken  in  1  decode resolved a taken branch/jump this cycle
- br_target  in  ADDR_W  target for br_taken
- d_rs1, d_rs2  in  5  decode source registers
- d_use1, d_use2  in  1  decode actually reads rs1 / rs2
- e_valid, e_is_load  in  1  execute holds a valid load
- e_rd  in  5  execute destination register
- en_f, en_d, en_e, en_m, en_w  out  1  stage register (PC, F/D, D/E, E/M, M/W) may load
- bub_d, bub_e, bub_w  out  1  load a bubble (all-zero) into F/D, D/E, M/W instead of the stage's output
- redir_valid  out  1  fetch loads redir_pc as the next PC this cycle
- redir_pc  out  ADDR_W  latched branch target
- drop_fetch  out  1  current instruction response is wrong-path and must be ignored

## Operation
- mem_stall = d_req_valid & ~d_data_ok. Clears en_f, en_d, en_e and en_m; sets en_w=1 and bub_w=1.
- load_use = e_valid & e_is_load & e_rd!=0 & ((d_use1 & d_rs1==e_rd) | (d_use2 & d_rs2==e_rd)). Clears en_f and en_d; sets en_e=1 and bub_e=1. Suppressed while mem_stall.
- Priority: reset > mem_stall > load_use > fetch/branch.
- br_acc = br_taken & ~mem_stall & ~load_use. Only an accepted branch is acted on.
- Fetch FSM:
  - F_IDLE -> F_BUSY on i_req_valid & ~i_data_ok.
  - F_BUSY -> F_IDLE on i_data_ok.
  - F_BUSY -> F_DROP on br_acc & ~i_data_ok.
  - F_DROP -> F_IDLE on i_data_ok, with drop_fetch=1 that cycle.
  - A request answered in the cycle it is issued never leaves F_IDLE.
- redir_pend register:
  - Set on br_acc; redir_pc latched from br_target at the same edge.
  - redir_valid = redir_pend & state!=F_DROP & ~reset.
  - Cleared at the edge where redir_valid=1.
  - A new br_acc while redir_pend=1 overwrites redir_pc (the later branch wins).
- f_ok = i_data_ok & state!=F_DROP & ~redir_pend.
  - en_f = f_ok | redir_valid (gated by the stalls above).
  - bub_d = en_d & (~f_ok | br_acc). A wrong-path instruction fetched alongside an accepted branch is squashed.
- All other en_*=1 and bub_*=0 unless a rule above overrides them.
- While reset=1: all en_*=0, bub_*=0, redir_valid=0, drop_fetch=0. State goes to F_IDLE, redir_pend=0, redir_pc=0. Any outstanding fetch or redirect is abandoned (reset taken mid-operation).

## Timing
- All stage controls and drop_fetch are combinational from inputs and state, valid in the same cycle.
- redir_valid rises no earlier than one cycle after br_acc.
  - It is delayed until the F_DROP response has returned (the cycle after drop_fetch).
- Simultaneous br_acc and i_data_ok in F_BUSY: the response is squashed via bub_d and the FSM goes to F_IDLE; no F_DROP.
- Simultaneous mem_stall and load_use: only the mem_stall controls apply; the load-use bubble is inserted on the first cycle mem_stall drops.
- Stall held any number of cycles: all frozen registers keep their values.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs perf_cycles, perf_mem_stall, perf_lu_stall and perf_flush (each out, 64 bits).
  - Each is a free-running cycle count or a count of cycles with mem_stall, load_use or br_acc respectively.
  - All reset to 0 and wrap modulo 2^64.
- Macro undefined: these ports and counters do not exist; the remaining behaviour is identical.

## Test plan
- Reset, then i_req_valid=1 and i_data_ok=1 every cycle -> en_*=1, bub_*=0 each cycle; state stays F_IDLE.
- d_req_valid=1 with d_data_ok low for 3 cycles -> en_f/d/e/m=0 and bub_w=1 for 3 cycles; all return to 1 on the cycle d_data_ok=1.
- e_is_load, e_rd=5, d_rs2=5, d_use2=1 -> en_f=en_d=0 and bub_e=1 for one cycle. The same case with e_rd=0 -> no stall.
- Fetch pending (F_BUSY), br_taken with br_target=0x80000100, i_data_ok arrives 2 cycles later:
  - FSM passes through F_DROP; drop_fetch=1 on the response cycle.
  - redir_valid=1 with redir_pc=0x80000100 on the next cycle, then redir_valid=0.
- br_taken coinciding with i_data_ok in F_BUSY -> bub_d=1, no F_DROP, redir_valid one cycle later.
- reset asserted while in F_DROP with redir_pend=1 -> next cycle state F_IDLE and redir_valid=0. With PIPE_CTRL_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard/sequencing controller: stage enables, bubbles,
// wrong-path fetch drop and branch redirect. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic              i_data_ok,
  input  logic              d_req_valid,
  input  logic              d_data_ok,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [4:0]        d_rs1,
  input  logic [4:0]        d_rs2,
  input  logic              d_use1,
  input  logic              d_use2,
  input  logic              e_valid,
  input  logic              e_is_load,
  input  logic [4:0]        e_rd,
  output logic              en_f,
  output logic              en_d,
  output logic              en_e,
  output logic              en_m,
  output logic              en_w,
  output logic              bub_d,
  output logic              bub_e,
  output logic              bub_w,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_pc,
  output logic              drop_fetch
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [63:0]       perf_cycles,
  output logic [63:0]       perf_mem_stall,
  output logic [63:0]       perf_lu_stall,
  output logic [63:0]       perf_flush
`endif
);

  // state  | meaning
  // F_IDLE | no instruction fetch outstanding
  // F_BUSY | one fetch outstanding, response is on the correct path
  // F_DROP | one fetch outstanding, response is wrong-path and gets discarded
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_BUSY = 2'd1,
    F_DROP = 2'd2
  } fstate_t;

  fstate_t state;
  logic    redir_pend;

  logic mem_stall;
  logic load_use;
  logic br_acc;
  logic f_ok;
  logic hit_rs1;
  logic hit_rs2;

  assign mem_stall = d_req_valid & ~d_data_ok;
  assign hit_rs1   = d_use1 & (d_rs1 == e_rd);
  assign hit_rs2   = d_use2 & (d_rs2 == e_rd);
  assign load_use  = ~mem_stall & e_valid & e_is_load & (e_rd != 5'd0) & (hit_rs1 | hit_rs2);
  assign br_acc    = br_taken & ~mem_stall & ~load_use;

  // The redirect waits for the wrong-path response so fetch sees it only once.
  assign redir_valid = redir_pend & (state != F_DROP) & ~reset;
  assign f_ok        = i_data_ok & (state != F_DROP) & ~redir_pend;
  assign drop_fetch  = i_data_ok & (state == F_DROP) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= F_IDLE;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
    end else begin
      case (state)
        F_IDLE: if (i_req_valid & ~i_data_ok) state <= F_BUSY;
        F_BUSY: begin
          if (i_data_ok)   state <= F_IDLE;
          else if (br_acc) state <= F_DROP;
        end
        F_DROP: if (i_data_ok) state <= F_IDLE;
        default: state <= F_IDLE;
      endcase

      // A later accepted branch overrides any redirect still pending.
      if (br_acc) begin
        redir_pend <= 1'b1;
        redir_pc   <= br_target;
      end else if (redir_valid) begin
        redir_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    en_f  = f_ok | redir_valid;
    en_d  = 1'b1;
    en_e  = 1'b1;
    en_m  = 1'b1;
    en_w  = 1'b1;
    bub_e = 1'b0;
    bub_w = 1'b0;
    if (reset) begin
      en_f = 1'b0;
      en_d = 1'b0;
      en_e = 1'b0;
      en_m = 1'b0;
      en_w = 1'b0;
    end else if (mem_stall) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      en_m  = 1'b0;
      bub_w = 1'b1;
    end else if (load_use) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      bub_e = 1'b1;
    end
    bub_d = en_d & (~f_ok | br_acc);
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles    <= '0;
      perf_mem_stall <= '0;
      perf_lu_stall  <= '0;
      perf_flush     <= '0;
    end else begin
      perf_cycles <= perf_cycles + 64'd1;
      if (mem_stall) perf_mem_stall <= perf_mem_stall + 64'd1;
      if (load_use)  perf_lu_stall  <= perf_lu_stall + 64'd1;
      if (br_acc)    perf_flush     <= perf_flush + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a reference model pushes expected outputs
// each cycle; they are popped and compared against the DUT mid-cycle.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_data_ok, d_req_valid, d_data_ok, br_taken;
  logic [63:0] br_target;
  logic [4:0]  d_rs1, d_rs2, e_rd;
  logic        d_use1, d_use2, e_valid, e_is_load;
  logic        en_f, en_d, en_e, en_m, en_w, bub_d, bub_e, bub_w;
  logic        redir_valid, drop_fetch;
  logic [63:0] redir_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [63:0] perf_cycles, perf_mem_stall, perf_lu_stall, perf_flush;
  logic [63:0] m_cyc, m_ms, m_lu, m_fl;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_data_ok(i_data_ok),
    .d_req_valid(d_req_valid), .d_data_ok(d_data_ok),
    .br_taken(br_taken), .br_target(br_target),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1), .d_use2(d_use2),
    .e_valid(e_valid), .e_is_load(e_is_load), .e_rd(e_rd),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .bub_d(bub_d), .bub_e(bub_e), .bub_w(bub_w),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .drop_fetch(drop_fetch)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_mem_stall(perf_mem_stall),
    .perf_lu_stall(perf_lu_stall), .perf_flush(perf_flush)
`endif
  );

  typedef struct {
    logic [9:0]  ctl;
    logic [63:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  string       phase = "init";

  // reference model state: 0 idle, 1 busy, 2 drop
  int          m_st;
  logic        m_pend;
  logic [63:0] m_pc;
  logic        m_ba, m_rv, m_ms_c, m_lu_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h expected %h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] dut_ctl();
    return {en_f, en_d, en_e, en_m, en_w, bub_d, bub_e, bub_w, redir_valid, drop_fetch};
  endfunction

  // Compute expected outputs for the current inputs, then compare 1ns later.
  task automatic drive();
    exp_t e, o;
    logic ef, ed, ee, em, ew, bd, be, bw, df, fok;
    m_ms_c = d_req_valid && !d_data_ok;
    m_lu_c = !m_ms_c && e_valid && e_is_load && (e_rd != 0) &&
             ((d_use1 && d_rs1 == e_rd) || (d_use2 && d_rs2 == e_rd));
    m_ba   = br_taken && !m_ms_c && !m_lu_c;
    m_rv   = m_pend && (m_st != 2) && !reset;
    fok    = i_data_ok && (m_st != 2) && !m_pend;
    df     = (m_st == 2) && i_data_ok && !reset;
    if (reset) begin
      {ef, ed, ee, em, ew, bd, be, bw} = 8'b0;
    end else begin
      ef = (m_ms_c || m_lu_c) ? 1'b0 : (fok || m_rv);
      ed = !(m_ms_c || m_lu_c);
      ee = !m_ms_c;
      em = !m_ms_c;
      ew = 1'b1;
      bd = ed && (!fok || m_ba);
      be = m_lu_c;
      bw = m_ms_c;
    end
    e.ctl = {ef, ed, ee, em, ew, bd, be, bw, m_rv, df};
    e.pc  = m_pc;
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    chk("ctl", {54'd0, dut_ctl()}, {54'd0, o.ctl});
    chk("redir_pc", redir_pc, o.pc);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, m_cyc);
    chk("perf_mem_stall", perf_mem_stall, m_ms);
    chk("perf_lu_stall", perf_lu_stall, m_lu);
    chk("perf_flush", perf_flush, m_fl);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_st = 0; m_pend = 1'b0; m_pc = '0;
`ifdef PIPE_CTRL_PERF_EN
      m_cyc = '0; m_ms = '0; m_lu = '0; m_fl = '0;
`endif
    end else begin
      case (m_st)
        0: if (i_req_valid && !i_data_ok) m_st = 1;
        1: if (i_data_ok) m_st = 0; else if (m_ba) m_st = 2;
        default: if (i_data_ok) m_st = 0;
      endcase
      if (m_ba) begin m_pend = 1'b1; m_pc = br_target; end
      else if (m_rv) m_pend = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
      m_cyc++;
      if (m_ms_c) m_ms++;
      if (m_lu_c) m_lu++;
      if (m_ba)   m_fl++;
`endif
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    drive();
    tick();
  endtask

  task automatic idle();
    reset = 1'b0; i_req_valid = 1'b0; i_data_ok = 1'b0; d_req_valid = 1'b0;
    d_data_ok = 1'b0; br_taken = 1'b0; br_target = '0; d_rs1 = '0; d_rs2 = '0;
    d_use1 = 1'b0; d_use2 = 1'b0; e_valid = 1'b0; e_is_load = 1'b0; e_rd = '0;
  endtask

  task automatic hazard(input logic [4:0] rd);
    e_valid = 1'b1; e_is_load = 1'b1; e_rd = rd; d_rs2 = 5'd5; d_use2 = 1'b1; d_rs1 = 5'd9;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    m_st = 0; m_pend = 1'b0; m_pc = '0;
`ifdef PIPE_CTRL_PERF_EN
    m_cyc = '0; m_ms = '0; m_lu = '0; m_fl = '0;
`endif
    @(negedge clk);
    phase = "reset";
    tick();
    drive();
    chk("rst_ctl", {54'd0, dut_ctl()}, 64'd0);
    tick();

    phase = "stream";
    idle(); i_req_valid = 1'b1; i_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive();
      chk("stream_ctl", {54'd0, dut_ctl()}, 64'b11111_000_00);
      tick();
    end

    phase = "mem_stall";
    d_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive();
      chk("ms_en", {59'd0, en_f, en_d, en_e, en_m, bub_w}, 64'b00001);
      tick();
    end
    d_data_ok = 1'b1;
    drive();
    chk("ms_release", {59'd0, en_f, en_d, en_e, en_m, bub_w}, 64'b11110);
    tick();

    phase = "load_use";
    idle(); i_req_valid = 1'b1; i_data_ok = 1'b1; hazard(5'd5);
    drive();
    chk("lu_stall", {61'd0, en_f, en_d, bub_e}, 64'b001);
    tick();
    e_valid = 1'b0;
    cyc();
    hazard(5'd0);
    drive();
    chk("lu_x0", {61'd0, en_f, en_d, bub_e}, 64'b110);
    tick();

    phase = "br_drop";
    idle(); i_req_valid = 1'b1;
    cyc();
    i_req_valid = 1'b0; br_taken = 1'b1; br_target = 64'h8000_0100;
    cyc();
    br_taken = 1'b0;
    drive();
    chk("wait_rv", {63'd0, redir_valid}, 64'd0);
    tick();
    i_data_ok = 1'b1;
    drive();
    chk("drop", {63'd0, drop_fetch}, 64'd1);
    tick();
    i_data_ok = 1'b0;
    drive();
    chk("rv_up", {63'd0, redir_valid}, 64'd1);
    chk("rv_pc", redir_pc, 64'h8000_0100);
    tick();
    drive();
    chk("rv_once", {63'd0, redir_valid}, 64'd0);
    tick();

    phase = "br_coinc";
    idle(); i_req_valid = 1'b1;
    cyc();
    i_req_valid = 1'b0; br_taken = 1'b1; i_data_ok = 1'b1; br_target = 64'h0000_0000_1234_5678;
    drive();
    chk("squash", {62'd0, bub_d, drop_fetch}, 64'b10);
    tick();
    idle();
    drive();
    chk("rv_next", {63'd0, redir_valid}, 64'd1);
    tick();
    cyc();

    phase = "ms_lu";
    idle(); i_req_valid = 1'b1; i_data_ok = 1'b1; hazard(5'd5); d_req_valid = 1'b1;
    drive();
    chk("both", {61'd0, bub_w, bub_e, en_e}, 64'b100);
    tick();
    d_data_ok = 1'b1;
    drive();
    chk("lu_after", {61'd0, bub_w, bub_e, en_d}, 64'b010);
    tick();

    phase = "br_twice";
    idle(); br_taken = 1'b1; br_target = 64'hAAAA_0000;
    cyc();
    br_target = 64'hBBBB_0000;
    cyc();
    br_taken = 1'b0;
    drive();
    chk("later_wins", redir_pc, 64'hBBBB_0000);
    tick();

    phase = "rst_drop";
    idle(); i_req_valid = 1'b1;
    cyc();
    i_req_valid = 1'b0; br_taken = 1'b1; br_target = 64'hDEAD_BEEF;
    cyc();
    idle(); reset = 1'b1;
    cyc();
    reset = 1'b0; i_data_ok = 1'b1;
    drive();
    chk("rst_rv", {62'd0, redir_valid, drop_fetch}, 64'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_perf", perf_cycles | perf_mem_stall | perf_lu_stall | perf_flush, 64'd0);
`endif
    tick();

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      i_req_valid = $urandom_range(0, 1);
      i_data_ok   = $urandom_range(0, 1);
      d_req_valid = ($urandom_range(0, 3) == 0);
      d_data_ok   = $urandom_range(0, 1);
      br_taken    = ($urandom_range(0, 4) == 0);
      br_target   = {$urandom, $urandom};
      d_rs1       = 5'($urandom_range(0, 3));
      d_rs2       = 5'($urandom_range(0, 3));
      d_use1      = $urandom_range(0, 1);
      d_use2      = $urandom_range(0, 1);
      e_valid     = $urandom_range(0, 1);
      e_is_load   = $urandom_range(0, 1);
      e_rd        = 5'($urandom_range(0, 3));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
